// File: rtl/chaser_sequencer.sv
// LED chaser: steps a WIDTH-bit pattern (rotate left/right, bounce, fill) at a
// programmable rate, with pause/stop control and mode changes deferred to period boundaries.
module chaser_sequencer #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SPD_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             stop,
    input  logic             mode_req,
    input  logic [1:0]       mode_sel,
    input  logic [SPD_W-1:0] speed,
    output logic [WIDTH-1:0] leds,
    output logic             busy,
    output logic             mode_ack,
    output logic             cycle_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam logic [1:0] MODE_ROTL   = 2'd0;
    localparam logic [1:0] MODE_ROTR   = 2'd1;
    localparam logic [1:0] MODE_BOUNCE = 2'd2;
    localparam logic [1:0] MODE_FILL   = 2'd3;

    state_t           state;
    logic [1:0]       mode;
    logic             pend_valid;
    logic [1:0]       pend_mode;
    logic [SPD_W-1:0] cnt;
    logic             bounce_down;

    logic [WIDTH-1:0] step_leds;
    logic             step_down;
    logic             wrap_c;
    logic             cnt_hit_c;

    function automatic logic [WIDTH-1:0] start_val(input logic [1:0] m);
        logic [WIDTH-1:0] v;
        case (m)
            MODE_ROTR: v = {1'b1, {(WIDTH-1){1'b0}}};
            MODE_FILL: v = '0;
            default:   v = WIDTH'(1);
        endcase
        return v;
    endfunction

    // Next pattern for the active mode; bounce direction flips at either end
    always_comb begin
        step_leds = leds;
        step_down = bounce_down;
        case (mode)
            MODE_ROTL: step_leds = {leds[WIDTH-2:0], leds[WIDTH-1]};
            MODE_ROTR: step_leds = {leds[0], leds[WIDTH-1:1]};
            MODE_BOUNCE: begin
                if (bounce_down) begin
                    step_leds = leds >> 1;
                    if (leds[1]) step_down = 1'b0;
                end else if (leds[WIDTH-1]) begin
                    step_leds = leds >> 1;
                    step_down = 1'b1;
                end else begin
                    step_leds = leds << 1;
                end
            end
            default:   step_leds = (&leds) ? '0 : {leds[WIDTH-2:0], 1'b1};
        endcase
    end

    assign wrap_c    = (step_leds == start_val(mode));
    assign cnt_hit_c = (cnt == speed);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            mode        <= MODE_ROTL;
            pend_valid  <= 1'b0;
            pend_mode   <= MODE_ROTL;
            cnt         <= '0;
            bounce_down <= 1'b0;
            leds        <= '0;
            busy        <= 1'b0;
            mode_ack    <= 1'b0;
            cycle_done  <= 1'b0;
        end else begin
            mode_ack   <= 1'b0;
            cycle_done <= 1'b0;
            if (stop) begin
                // A request arriving with stop is newer than any pending one
                state       <= IDLE;
                leds        <= '0;
                cnt         <= '0;
                busy        <= 1'b0;
                bounce_down <= 1'b0;
                pend_valid  <= 1'b0;
                if (mode_req) begin
                    mode     <= mode_sel;
                    mode_ack <= 1'b1;
                end else if (pend_valid) begin
                    mode     <= pend_mode;
                    mode_ack <= 1'b1;
                end
            end else if (state == IDLE) begin
                if (mode_req) begin
                    mode     <= mode_sel;
                    mode_ack <= 1'b1;
                end
                if (enable) begin
                    state       <= RUN;
                    busy        <= 1'b1;
                    cnt         <= '0;
                    bounce_down <= 1'b0;
                    leds        <= start_val(mode_req ? mode_sel : mode);
                end
            end else begin
                if (mode_req) begin
                    pend_valid <= 1'b1;
                    pend_mode  <= mode_sel;
                end
                if (!enable) begin
                    state <= PAUSE;
                end else begin
                    state <= RUN;
                    if (!cnt_hit_c) begin
                        cnt <= cnt + SPD_W'(1);
                    end else begin
                        cnt <= '0;
                        if (wrap_c) cycle_done <= 1'b1;
                        if (wrap_c && pend_valid) begin
                            // Old pending applies now; a same-cycle request stays pending
                            mode        <= pend_mode;
                            mode_ack    <= 1'b1;
                            leds        <= start_val(pend_mode);
                            bounce_down <= 1'b0;
                            pend_valid  <= mode_req;
                        end else begin
                            leds        <= step_leds;
                            bounce_down <= step_down;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_chaser_sequencer.sv
// Bench for chaser_sequencer: pattern-index reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_chaser_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       stop;
    logic       mode_req;
    logic [1:0] mode_sel;
    logic [3:0] speed;
    logic [7:0] leds;
    logic       busy;
    logic       mode_ack;
    logic       cycle_done;

    int n_checks = 0;
    int n_pass   = 0;

    chaser_sequencer #(.WIDTH(8), .SPD_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .stop       (stop),
        .mode_req   (mode_req),
        .mode_sel   (mode_sel),
        .speed      (speed),
        .leds       (leds),
        .busy       (busy),
        .mode_ack   (mode_ack),
        .cycle_done (cycle_done)
    );

    always #5 clk = ~clk;

    // Reference: position within the mode's period, patterns from closed-form arithmetic
    typedef struct {
        logic       run;
        int         idx;
        int         cnt;
        logic [1:0] mode;
        logic       pv;
        logic [1:0] pm;
        logic       ack;
        logic       done;
    } mstate_t;

    mstate_t m;

    function automatic int period(input logic [1:0] md);
        case (md)
            2'd2:    return 14;
            2'd3:    return 9;
            default: return 8;
        endcase
    endfunction

    function automatic logic [7:0] pattern(input logic [1:0] md, input int idx);
        case (md)
            2'd0:    return 8'(1 << idx);
            2'd1:    return 8'(128 >> idx);
            2'd2:    return (idx <= 7) ? 8'(1 << idx) : 8'(1 << (14 - idx));
            default: return 8'((1 << idx) - 1);
        endcase
    endfunction

    function automatic mstate_t model_reset();
        mstate_t r;
        r.run = 1'b0; r.idx = 0; r.cnt = 0; r.mode = 2'd0;
        r.pv = 1'b0; r.pm = 2'd0; r.ack = 1'b0; r.done = 1'b0;
        return r;
    endfunction

    function automatic mstate_t model_step(input mstate_t s, input logic en, input logic st,
                                           input logic mr, input logic [1:0] ms, input int spd);
        mstate_t n = s;
        n.ack  = 1'b0;
        n.done = 1'b0;
        if (st) begin
            n.run = 1'b0; n.idx = 0; n.cnt = 0; n.pv = 1'b0;
            if (mr) begin
                n.mode = ms; n.ack = 1'b1;
            end else if (s.pv) begin
                n.mode = s.pm; n.ack = 1'b1;
            end
        end else if (!s.run) begin
            if (mr) begin
                n.mode = ms; n.ack = 1'b1;
            end
            if (en) begin
                n.run = 1'b1; n.idx = 0; n.cnt = 0;
            end
        end else begin
            if (en) begin
                if (s.cnt == spd) begin
                    n.cnt = 0;
                    n.idx = (s.idx + 1) % period(s.mode);
                    if (n.idx == 0) begin
                        n.done = 1'b1;
                        if (s.pv) begin
                            n.mode = s.pm; n.ack = 1'b1; n.pv = 1'b0;
                        end
                    end
                end else begin
                    n.cnt = (s.cnt + 1) % 16;
                end
            end
            if (mr) begin
                n.pv = 1'b1; n.pm = ms;
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) m <= model_reset();
        else      m <= model_step(m, enable, stop, mode_req, mode_sel, int'(speed));
    end

    task automatic check(input string name, input int got, input int want);
        n_checks++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
    endtask

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (rst) begin
            check("model_leds", int'(leds), int'(m.run ? pattern(m.mode, m.idx) : 8'h00));
            check("model_busy", int'(busy), int'(m.run));
            check("model_ack", int'(mode_ack), int'(m.ack));
            check("model_done", int'(cycle_done), int'(m.done));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_req(input logic [1:0] sel);
        mode_sel = sel;
        mode_req = 1'b1;
        tick();
        mode_req = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic wait_leds(input logic [7:0] v, input int lim, input string nm);
        int found = 0;
        for (int i = 0; i < lim && found == 0; i++) begin
            if (leds == v) found = 1;
            else tick();
        end
        check(nm, found, 1);
    endtask

    initial begin
        logic [7:0] exp_rotl [9];
        int n_done, first_done, second_done, acks;
        exp_rotl = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};

        rst = 1'b0; enable = 1'b0; stop = 1'b0; mode_req = 1'b0; mode_sel = 2'd0; speed = 4'd0;
        tick(); tick();
        rst = 1'b1;
        check("reset_leds", int'(leds), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_ack", int'(mode_ack), 0);
        check("reset_done", int'(cycle_done), 0);

        // ROTL at full speed
        enable = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            check("rotl_seq", int'(leds), int'(exp_rotl[i]));
            check("rotl_done", int'(cycle_done), (i == 8) ? 1 : 0);
        end
        enable = 1'b0;
        pulse_stop();

        // BOUNCE with speed 3: period 56 clocks
        pulse_req(2'd2);
        speed = 4'd3;
        enable = 1'b1;
        tick();
        check("bounce_load", int'(leds), 1);
        n_done = 0; first_done = 0; second_done = 0;
        for (int c = 1; c <= 112; c++) begin
            tick();
            if (cycle_done) begin
                n_done++;
                if (n_done == 1) first_done = c;
                if (n_done == 2) second_done = c;
            end
        end
        check("bounce_ndone", n_done, 2);
        check("bounce_first", first_done, 56);
        check("bounce_second", second_done, 112);
        enable = 1'b0;
        pulse_stop();

        // Latest pending request wins, applied at the wrap with a single ack
        pulse_req(2'd0);
        speed = 4'd0;
        enable = 1'b1;
        wait_leds(8'h08, 20, "wait_08");
        pulse_req(2'd3);
        pulse_req(2'd1);
        acks = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (mode_ack) begin
                acks++;
                check("wrap_leds", int'(leds), 8'h80);
                check("wrap_done", int'(cycle_done), 1);
            end
        end
        check("wrap_acks", acks, 1);
        enable = 1'b0;
        pulse_stop();

        // Pause mid-count and resume with the remaining count
        pulse_req(2'd0);
        speed = 4'd3;
        enable = 1'b1;
        wait_leds(8'h10, 40, "wait_10");
        tick();
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("pause_leds", int'(leds), 8'h10);
            check("pause_busy", int'(busy), 1);
        end
        enable = 1'b1;
        tick(); tick();
        check("resume_hold", int'(leds), 8'h10);
        tick();
        check("resume_step", int'(leds), 8'h20);
        enable = 1'b0;
        pulse_stop();

        // Stop with a pending request applies and acks it
        pulse_req(2'd3);
        speed = 4'd0;
        enable = 1'b1;
        wait_leds(8'h01, 20, "wait_fill01");
        pulse_req(2'd2);
        wait_leds(8'h07, 20, "wait_fill07");
        stop = 1'b1;
        enable = 1'b0;
        tick();
        stop = 1'b0;
        check("stop_leds", int'(leds), 0);
        check("stop_busy", int'(busy), 0);
        check("stop_ack", int'(mode_ack), 1);

        // Async reset mid-run discards the pending request
        speed = 4'd1;
        enable = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        pulse_req(2'd0);
        tick();
        #2;
        rst = 1'b0;
        #1;
        check("areset_leds", int'(leds), 0);
        check("areset_busy", int'(busy), 0);
        check("areset_ack", int'(mode_ack), 0);
        tick();
        rst = 1'b1;
        tick();
        check("post_reset_load", int'(leds), 1);
        acks = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (mode_ack) acks++;
        end
        check("post_reset_acks", acks, 0);

        // mode_req coinciding with stop
        enable = 1'b0;
        mode_sel = 2'd3;
        mode_req = 1'b1;
        stop = 1'b1;
        tick();
        mode_req = 1'b0;
        stop = 1'b0;
        check("stopreq_ack", int'(mode_ack), 1);
        check("stopreq_leds", int'(leds), 0);
        speed = 4'd0;
        enable = 1'b1;
        tick(); tick();
        check("stopreq_fill", int'(leds), 1);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule

// File: doc/chaser_sequencer.md
CHASER_SEQUENCER -- requirements
Module: chaser_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 8: LED vector width; patterns below are given for WIDTH=8.
REQ-002 SHALL have parameter SPD_W, default 4: width of the speed input.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port enable  input  1  level; 1 = run, 0 = pause.
REQ-006 SHALL have port stop  input  1  single-cycle pulse; return to IDLE.
REQ-007 SHALL have port mode_req  input  1  single-cycle pulse requesting a mode change.
REQ-008 SHALL have port mode_sel  input  2  requested mode; sampled only when mode_req=1.
REQ-009 SHALL have port speed  input  SPD_W  step period minus one, in clocks.
REQ-010 SHALL have port leds  output  WIDTH  current pattern; registered.
REQ-011 SHALL have port busy  output  1  1 in RUN or PAUSE.
REQ-012 SHALL have port mode_ack  output  1  one-cycle pulse when a requested mode becomes active.
REQ-013 SHALL have port cycle_done  output  1  one-cycle pulse on the step that returns leds to the mode start value.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, PAUSE; precedence per cycle: stop > enable/state transition > mode request capture.
REQ-015 SHALL define modes: 0 ROTL (start 0x01, 0x01->0x02->...->0x80->0x01); 1 ROTR (start 0x80, 0x80->0x40->...->0x01->0x80); 2 BOUNCE (start 0x01, up to 0x80 then down to 0x01, period 14 steps); 3 FILL (start 0x00, 0x00->0x01->0x03->...->0xFF->0x00, period 9 steps).
REQ-016 IDLE: leds=0, busy=0; enable=1 SHALL move to RUN and load the active mode's start value into leds on the same edge; the step counter is cleared.
REQ-017 RUN: the step counter SHALL count 0..speed; when it equals speed, the counter clears and leds advance one step (step period = speed+1 clocks; speed=0 advances every clock).
REQ-018 The speed input SHALL be sampled on every cycle; if it is lowered below the current count, the counter still advances only on equality, so it wraps through 2^SPD_W before stepping (no early step).
REQ-019 RUN with enable=0 SHALL go to PAUSE; leds and the step counter SHALL hold, with no step and no cycle_done.
REQ-020 PAUSE with enable=1 SHALL return to RUN, resuming the count from its held value.
REQ-021 stop=1 in any state SHALL go to IDLE next edge: leds=0, counter=0; any pending mode SHALL be applied and acked in that same cycle.
REQ-022 In IDLE, a mode_req SHALL update the active mode on the next edge, with mode_ack=1 in that cycle.
REQ-023 In RUN or PAUSE, a mode_req SHALL be stored as pending; a later request before application SHALL overwrite it (latest wins), and only one ack is issued.
REQ-024 A pending mode SHALL be applied on the RUN step that would produce the current mode's start value: leds load the new mode's start value instead, and cycle_done=1 and mode_ack=1 on that edge.
REQ-025 cycle_done SHALL pulse exactly once per completed period: ROTL/ROTR every 8 steps, BOUNCE every 14, FILL every 9, and never on the initial load out of IDLE.
REQ-026 If mode_req coincides with stop, the request SHALL be applied in the same cycle as the stop, with one ack.
REQ-027 If mode_req coincides with the application step, the new request SHALL become pending for the next period and the old pending value SHALL apply now.

Reset
REQ-028 rst=0 SHALL immediately, independent of clk, force state=IDLE, active mode=0, pending cleared, counter=0, leds=0, busy=0, mode_ack=0, cycle_done=0.
REQ-029 Reset asserted mid-run SHALL discard any pending mode without an ack; after release the block behaves as after power-up.

Verification
REQ-030 Reset release, enable=1, speed=0, mode 0 -> leds 0x01,0x02,...,0x80,0x01 on consecutive clocks; cycle_done on the 0x01 step only.
REQ-031 speed=3, mode 2 -> leds change every 4 clocks through 0x01..0x80..0x01; cycle_done every 56 clocks.
REQ-032 While running mode 0, pulse mode_req with mode_sel=3 at leds=0x08, then again with mode_sel=1 -> at the wrap step leds=0x80, mode_ack and cycle_done one cycle each, with a single ack.
REQ-033 enable dropped at leds=0x10 for 5 clocks -> leds hold 0x10 and busy=1; after re-enable, steps resume with the remaining count.
REQ-034 stop pulse at leds=0x07 (mode 3) with a pending request -> next edge leds=0x00, busy=0, mode_ack=1.
REQ-035 rst=0 asserted between clock edges during RUN -> leds=0 and busy=0 before the next edge; no mode_ack ever issued for the discarded pending request.
